// File: rtl/mul_share_arbiter_pkg.sv
// Shared types, default sizing and pointer helper for the multiplier-sharing arbiter.
// Build option: define MUL_SHARE_ARBITER_RR_EN for round-robin grants; default is fixed priority.
package mul_share_pkg;

    localparam int unsigned N_DEF    = 8;
    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned LAT_DEF  = 2;

    typedef logic [$clog2(NREQ_DEF)-1:0] id_t;

    // Stage layout at the default sizing; parameterised instances use matching local widths.
    typedef struct packed {
        logic             vld;
        id_t              id;
        logic             signed_mul;
        logic [N_DEF-1:0] a;
        logic [N_DEF-1:0] b;
    } mul_stage_t;

    function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned nreq);
        return (idx + 1 >= nreq) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Requester/result bundle between requester blocks and the shared multiplier.
// Build option MUL_SHARE_ARBITER_RR_EN does not change this interface.
interface mul_share_arbiter_if #(
    parameter int unsigned n    = 8,
    parameter int unsigned NREQ = 4
);
    localparam int unsigned ID_W = $clog2(NREQ);

    logic [NREQ-1:0]   req_vld;
    logic [NREQ*n-1:0] req_a;
    logic [NREQ*n-1:0] req_b;
    logic [NREQ-1:0]   req_signed;
    logic [NREQ-1:0]   req_rdy;
    logic              res_vld;
    logic [ID_W-1:0]   res_id;
    logic [2*n-1:0]    res;

    modport master (
        output req_vld, req_a, req_b, req_signed,
        input  req_rdy, res_vld, res_id, res
    );

    modport slave (
        input  req_vld, req_a, req_b, req_signed,
        output req_rdy, res_vld, res_id, res
    );

endinterface

// File: rtl/mul_share_arbiter_mul_pipe.sv
// Fixed-latency signed/unsigned multiplier: one product register plus LAT-1 retiming stages.
// Unaffected by MUL_SHARE_ARBITER_RR_EN.
module mul_pipe
    import mul_share_pkg::*;
#(
    parameter int unsigned n    = N_DEF,
    parameter int unsigned LAT  = LAT_DEF,
    parameter int unsigned ID_W = $bits(id_t)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_vld,
    input  logic [ID_W-1:0] in_id,
    input  logic            in_signed,
    input  logic [n-1:0]    in_a,
    input  logic [n-1:0]    in_b,
    output logic            out_vld,
    output logic [ID_W-1:0] out_id,
    output logic [2*n-1:0]  out_res
);

    logic [2*n-1:0]  ext_a;
    logic [2*n-1:0]  ext_b;
    logic [2*n-1:0]  prod;

    logic [LAT-1:0]  vld;
    logic [ID_W-1:0] id_q   [LAT];
    logic [2*n-1:0]  prod_q [LAT];

    // Low 2n bits of the extended product are exact for both signednesses.
    always_comb begin
        ext_a = in_signed ? {{n{in_a[n-1]}}, in_a} : {{n{1'b0}}, in_a};
        ext_b = in_signed ? {{n{in_b[n-1]}}, in_b} : {{n{1'b0}}, in_b};
        prod  = ext_a * ext_b;
    end

    // Data registers load only with a valid token, so outputs hold between results.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int unsigned k = 0; k < LAT; k++) begin
                id_q[k]   <= '0;
                prod_q[k] <= '0;
            end
        end else begin
            vld[0] <= in_vld;
            if (in_vld) begin
                id_q[0]   <= in_id;
                prod_q[0] <= prod;
            end
            for (int unsigned k = 1; k < LAT; k++) begin
                vld[k] <= vld[k-1];
                if (vld[k-1]) begin
                    id_q[k]   <= id_q[k-1];
                    prod_q[k] <= prod_q[k-1];
                end
            end
        end
    end

    assign out_vld = vld[LAT-1];
    assign out_id  = id_q[LAT-1];
    assign out_res = prod_q[LAT-1];

endmodule

// File: rtl/mul_share_arbiter.sv
// Grants one of NREQ requesters per cycle into a shared pipelined multiplier.
// Define MUL_SHARE_ARBITER_RR_EN for a round-robin pointer; otherwise lowest index wins.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int unsigned n    = N_DEF,
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned LAT  = LAT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    mul_share_arbiter_if.slave bus
);

    localparam int unsigned ID_W = $clog2(NREQ);

    logic [ID_W-1:0] ptr;
    logic [NREQ-1:0] gnt;
    logic            gnt_any;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W-1:0] idx;
    logic [n-1:0]    sel_a;
    logic [n-1:0]    sel_b;
    logic            sel_signed;
    logic [n-1:0]    a_arr [NREQ];
    logic [n-1:0]    b_arr [NREQ];

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            a_arr[i] = bus.req_a[i*n +: n];
            b_arr[i] = bus.req_b[i*n +: n];
        end
    end

    // First valid requester at or after ptr, wrapping; nothing granted during reset.
    always_comb begin
        gnt        = '0;
        gnt_any    = 1'b0;
        gnt_idx    = '0;
        idx        = '0;
        sel_a      = '0;
        sel_b      = '0;
        sel_signed = 1'b0;
        if (!rst) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx = ID_W'((32'(ptr) + k) % NREQ);
                if (!gnt_any && bus.req_vld[idx]) begin
                    gnt_any    = 1'b1;
                    gnt[idx]   = 1'b1;
                    gnt_idx    = idx;
                    sel_a      = a_arr[idx];
                    sel_b      = b_arr[idx];
                    sel_signed = bus.req_signed[idx];
                end
            end
        end
    end

`ifdef MUL_SHARE_ARBITER_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= ID_W'(next_ptr(32'(gnt_idx), NREQ));
        end
    end
`else
    assign ptr = '0;
`endif

    assign bus.req_rdy = gnt;

    mul_pipe #(
        .n    (n),
        .LAT  (LAT),
        .ID_W (ID_W)
    ) u_mul_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (gnt_any),
        .in_id     (gnt_idx),
        .in_signed (sel_signed),
        .in_a      (sel_a),
        .in_b      (sel_b),
        .out_vld   (bus.res_vld),
        .out_id    (bus.res_id),
        .out_res   (bus.res)
    );

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter (n=4, NREQ=4, LAT=2); honours MUL_SHARE_ARBITER_RR_EN.
module tb_mul_share_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned NR  = 4;
    localparam int unsigned LTC = 2;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;

    mul_share_arbiter_if #(.n(N), .NREQ(NR)) bus ();

    mul_share_arbiter #(.n(N), .NREQ(NR), .LAT(LTC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         id;
        logic [7:0] p;
        int         due;
    } exp_t;

    exp_t       q[$];
    int         ptr_m;
    logic [3:0] exp_gnt;
    logic       prev_rst;
    logic [7:0] last_res;
    logic [1:0] last_id;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h cyc=%0d", name, act, want, cyc);
        end
    endtask

    function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b, input logic s);
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
        if (s && sa >= 8) sa -= 16;
        if (s && sb >= 8) sb -= 16;
        return 8'(sa * sb);
    endfunction

    // Predictor: expected grant from the requests the DUT sees this cycle.
    always @(negedge clk) begin
        int         gi;
        logic [3:0] g;
        logic [3:0] a;
        logic [3:0] b;
        exp_t       e;
        gi = -1;
        g  = '0;
        if (rst) begin
            ptr_m = 0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (gi < 0 && bus.req_vld[(ptr_m + k) % 4]) gi = (ptr_m + k) % 4;
            end
        end
        if (gi >= 0) g[gi] = 1'b1;
        chk("req_rdy", 32'(bus.req_rdy), 32'(g));
        if (gi >= 0) begin
            a     = bus.req_a[gi*4 +: 4];
            b     = bus.req_b[gi*4 +: 4];
            e.id  = gi;
            e.p   = ref_mul(a, b, bus.req_signed[gi]);
            e.due = cyc + int'(LTC);
            q.push_back(e);
`ifdef MUL_SHARE_ARBITER_RR_EN
            ptr_m = (gi + 1) % 4;
`endif
        end
        exp_gnt = g;
    end

    // Monitor: pops an expectation whenever a result is presented.
    always @(negedge clk) begin
        exp_t e;
        if (prev_rst) begin
            chk("rst_res_vld", 32'(bus.res_vld), 32'd0);
            chk("rst_res", 32'(bus.res), 32'd0);
            chk("rst_res_id", 32'(bus.res_id), 32'd0);
        end else if (bus.res_vld) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_res got_id=%0d got_res=%0h want=none cyc=%0d",
                         bus.res_id, bus.res, cyc);
            end else begin
                e = q.pop_front();
                chk("res_cycle", 32'(cyc), 32'(e.due));
                chk("res_id", 32'(bus.res_id), 32'(e.id));
                chk("res", 32'(bus.res), 32'(e.p));
            end
        end else begin
            chk("hold_res", 32'(bus.res), 32'(last_res));
            chk("hold_res_id", 32'(bus.res_id), 32'(last_id));
        end
        if (rst) begin
            while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
        end
        last_res = bus.res;
        last_id  = bus.res_id;
        prev_rst = rst;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] a, input logic [3:0] b,
                           input logic s);
        bus.req_vld[i]        = v;
        bus.req_a[i*4 +: 4]   = a;
        bus.req_b[i*4 +: 4]   = b;
        bus.req_signed[i]     = s;
    endtask

    task automatic clear_all();
        bus.req_vld    = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_signed = '0;
    endtask

    task automatic refresh(input int i);
        if (!bus.req_vld[i] || exp_gnt[i])
            set_req(i, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)));
    endtask

    initial begin
        cyc      = 0;
        checks   = 0;
        failures = 0;
        ptr_m    = 0;
        exp_gnt  = '0;
        prev_rst = 1'b1;
        last_res = '0;
        last_id  = '0;
        rst      = 1'b1;
        clear_all();
        repeat (3) next_cycle();
        rst = 1'b0;
        next_cycle();

        // Single unsigned request from requester 2: 15*15 = 0xE1.
        set_req(2, 1'b1, 4'hF, 4'hF, 1'b0);
        next_cycle();
        clear_all();
        repeat (3) next_cycle();

        // Signed and unsigned corners from requester 0, back to back.
        set_req(0, 1'b1, 4'h8, 4'h8, 1'b1); next_cycle();
        set_req(0, 1'b1, 4'hF, 4'h7, 1'b1); next_cycle();
        set_req(0, 1'b1, 4'h8, 4'h8, 1'b0); next_cycle();
        set_req(0, 1'b1, 4'hF, 4'h7, 1'b0); next_cycle();
        clear_all();
        repeat (3) next_cycle();

        // All four requesting for 8 cycles.
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 4; i++) refresh(i);
            next_cycle();
        end
        clear_all();
        repeat (3) next_cycle();

        // Eight back-to-back transfers alternating signedness.
        for (int c = 0; c < 8; c++) begin
            set_req(1, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'(c % 2));
            next_cycle();
        end
        clear_all();
        repeat (3) next_cycle();

        // Reset one cycle after a transfer from requester 1.
        set_req(1, 1'b1, 4'h9, 4'h5, 1'b1);
        next_cycle();
        clear_all();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        set_req(0, 1'b1, 4'h3, 4'h6, 1'b0);
        set_req(1, 1'b1, 4'hA, 4'h2, 1'b1);
        for (int c = 0; c < 3; c++) begin
            refresh(0);
            refresh(1);
            next_cycle();
        end
        clear_all();
        repeat (3) next_cycle();

        // Only requesters 3 and 0, continuously.
        for (int c = 0; c < 8; c++) begin
            refresh(3);
            refresh(0);
            next_cycle();
        end
        clear_all();
        repeat (3) next_cycle();

        // Random traffic with occasional reset.
        for (int c = 0; c < 300; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < 4; i++) begin
                if (!bus.req_vld[i] || exp_gnt[i]) begin
                    if ($urandom_range(0, 1) == 1) refresh(i);
                    else set_req(i, 1'b0, 4'h0, 4'h0, 1'b0);
                end
            end
            next_cycle();
        end
        rst = 1'b0;
        clear_all();
        repeat (6) next_cycle();

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
